// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment display path.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry 15 first: F E d C b A 9 8 7 6 5 4 3 2 1 0
    localparam logic [15:0][6:0] HEX_TO_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef struct packed {
        logic [3:0] value;
        logic       dp;
        logic       blank;
        logic       blink;
    } digit_attr_t;

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg_c
);

    assign seg_c = HEX_TO_SEG[value];

endmodule

// File: rtl/seg_display_scanner.sv
// Multiplexed common-anode seven-segment scanner with per-digit dp, blank, blink,
// leading-zero blanking and frame-synchronous (tear-free) display update.
module seg_display_scanner
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   blink_in,
    input  logic                    lz_blank_en,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_tick
);

    localparam int unsigned SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned BLK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [SLOT_W-1:0] slot_cnt;
    logic [IDX_W-1:0]  idx;
    logic [BLK_W-1:0]  blink_cnt;
    logic              blink_phase;
    logic              pending;
    logic              slot_end;
    logic              frame_end;
    logic              blink_wrap;

    digit_attr_t [NUM_DIGITS-1:0] in_attr;
    digit_attr_t [NUM_DIGITS-1:0] stage_attr;
    digit_attr_t [NUM_DIGITS-1:0] disp_attr;
    logic                         stage_lz;
    logic                         disp_lz;

    digit_attr_t           cur;
    logic [NUM_DIGITS-1:0] zero_from;
    logic                  lzb;
    logic [6:0]            hex_seg;
    logic [NUM_DIGITS-1:0] an_nxt;
    logic [6:0]            seg_nxt;
    logic                  dp_nxt;

    assign slot_end   = (slot_cnt == SLOT_W'(REFRESH_DIV - 1));
    assign frame_end  = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));
    assign blink_wrap = (blink_cnt == BLK_W'(BLINK_FRAMES - 1));

    always_comb begin
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            in_attr[i].value = digits_in[4*i +: 4];
            in_attr[i].dp    = dp_in[i];
            in_attr[i].blank = blank_in[i];
            in_attr[i].blink = blink_in[i];
        end
    end

    // Slot timer, scan index and blink phase; frame boundary is the index wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt    <= '0;
            idx         <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            slot_cnt <= slot_end ? '0 : slot_cnt + SLOT_W'(1);
            if (slot_end) begin
                idx <= frame_end ? '0 : idx + IDX_W'(1);
            end
            if (frame_end) begin
                blink_cnt <= blink_wrap ? '0 : blink_cnt + BLK_W'(1);
                if (blink_wrap) begin
                    blink_phase <= ~blink_phase;
                end
            end
        end
    end

    // Display registers change only at a frame boundary so a frame never mixes data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_attr <= '0;
            stage_lz   <= 1'b0;
            disp_attr  <= '0;
            disp_lz    <= 1'b0;
            pending    <= 1'b0;
        end else begin
            if (load) begin
                stage_attr <= in_attr;
                stage_lz   <= lz_blank_en;
            end
            if (frame_end && load) begin
                disp_attr <= in_attr;
                disp_lz   <= lz_blank_en;
                pending   <= 1'b0;
            end else if (frame_end && pending) begin
                disp_attr <= stage_attr;
                disp_lz   <= stage_lz;
                pending   <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // zero_from[i]: digit values i and above are all zero.
    always_comb begin : zero_scan
        logic all_zero;
        all_zero  = 1'b1;
        zero_from = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            all_zero     = all_zero && (disp_attr[i].value == 4'h0);
            zero_from[i] = all_zero;
        end
    end

    always_comb begin
        cur = disp_attr[idx];
        lzb = disp_lz && (idx != '0) && zero_from[idx];
    end

    seg_hex_decoder u_hex (
        .value (cur.value),
        .seg_c (hex_seg)
    );

    always_comb begin
        an_nxt  = '1;
        seg_nxt = SEG_BLANK;
        dp_nxt  = 1'b1;
        if (!(cur.blank || (cur.blink && blink_phase))) begin
            an_nxt = ~(NUM_DIGITS'(1) << idx);
            dp_nxt = ~cur.dp;
            if (!lzb) begin
                seg_nxt = hex_seg;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an         <= '1;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_nxt;
            seg        <= seg_nxt;
            dp         <= dp_nxt;
            frame_tick <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Scoreboard bench for seg_display_scanner: stimulus queues expected per-slot
// an/seg/dp, a negedge monitor compares every cycle of each output slot.
module tb_seg_display_scanner;

    localparam int unsigned ND = 4;
    localparam int unsigned RD = 4;
    localparam int unsigned BF = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [4*ND-1:0] digits_in;
    logic [ND-1:0]   dp_in;
    logic [ND-1:0]   blank_in;
    logic [ND-1:0]   blink_in;
    logic            lz_blank_en;
    logic            load;
    logic [ND-1:0]   an;
    logic [6:0]      seg;
    logic            dp;
    logic            frame_tick;

    typedef struct {
        int         slot;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc;
    bit   seen_tick = 1'b0;

    seg_display_scanner #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .blink_in    (blink_in),
        .lz_blank_en (lz_blank_en),
        .load        (load),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    // Edges since the last reset release.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, expected %0h (cyc %0d, t=%0t)", name, act, req, cyc, $time);
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    task automatic push(input int f, input int i, input logic [3:0] a, input logic [6:0] sg, input logic d);
        exp_t e;
        e.slot = 4 * f + i;
        e.an   = a;
        e.seg  = sg;
        e.dp   = d;
        exp_q.push_back(e);
    endtask

    // Frame of plain hex digits, optionally with digit 0 blinked dark.
    task automatic push_plain(input int f, input logic [15:0] d, input bit d0_dark);
        logic [3:0] a;
        for (int i = 0; i < 4; i++) begin
            a = 4'hF;
            a[i] = 1'b0;
            if (d0_dark && i == 0) push(f, i, 4'hF, 7'h7F, 1'b1);
            else                   push(f, i, a, hex7(d[4*i +: 4]), 1'b1);
        end
    endtask

    task automatic load_at(input int e, input logic [15:0] d, input logic [3:0] dpv,
                           input logic [3:0] bk, input logic [3:0] bl, input logic lz);
        while (cyc != e - 1) @(negedge clk);
        digits_in   = d;
        dp_in       = dpv;
        blank_in    = bk;
        blink_in    = bl;
        lz_blank_en = lz;
        load        = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        int s;
        if (!reset) begin
            check("frame_tick", frame_tick, (cyc > 0) && (cyc % 16 == 0));
            if (frame_tick && !seen_tick) begin
                seen_tick = 1'b1;
                check("first_tick_cycle", cyc, 16);
            end
            if (cyc >= 1) begin
                s = (cyc - 1) / 4;
                while (exp_q.size() > 0 && exp_q[0].slot < s) begin
                    check("missed_slot", s, exp_q[0].slot);
                    void'(exp_q.pop_front());
                end
                if (exp_q.size() > 0 && exp_q[0].slot == s) begin
                    check($sformatf("an_slot%0d", s), an, exp_q[0].an);
                    check($sformatf("seg_slot%0d", s), seg, exp_q[0].seg);
                    check($sformatf("dp_slot%0d", s), dp, exp_q[0].dp);
                    if ((cyc - 1) % 4 == 3) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: run did not complete (cyc %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0;
        blank_in = '0; blink_in = '0; lz_blank_en = 1'b0;
        #1;
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1'b1);
        check("rst_tick", frame_tick, 1'b0);
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;

        // Mid-scan reset while digit 1 is lit: outputs go dark without a clock edge.
        while (cyc != 6) @(negedge clk);
        check("prerst_an", an, 4'b1101);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_an", an, 4'hF);
        check("midrst_seg", seg, 7'h7F);
        check("midrst_dp", dp, 1'b1);
        check("midrst_tick", frame_tick, 1'b0);

        push_plain(0, 16'h0000, 1'b0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;

        push(1, 0, 4'b1110, 7'b0001110, 1'b1);
        push(1, 1, 4'b1101, 7'b0001000, 1'b1);
        push(1, 2, 4'b1011, 7'b0100100, 1'b1);
        push(1, 3, 4'b0111, 7'b1111001, 1'b1);
        load_at(8, 16'h12AF, 4'h0, 4'h0, 4'h0, 1'b0);

        // Mid-frame load must not disturb the frame being shown.
        push_plain(2, 16'h3333, 1'b0);
        load_at(22, 16'h3333, 4'h0, 4'h0, 4'h0, 1'b0);

        // Two loads in one frame: the later (0070, LZB on) wins.
        push(3, 0, 4'b1110, 7'b1000000, 1'b1);
        push(3, 1, 4'b1101, 7'b1111000, 1'b1);
        push(3, 2, 4'b1011, 7'h7F, 1'b1);
        push(3, 3, 4'b0111, 7'h7F, 1'b1);
        load_at(36, 16'h4567, 4'h0, 4'h0, 4'h0, 1'b0);
        load_at(40, 16'h0070, 4'h0, 4'h0, 4'h0, 1'b1);

        // Load on the boundary edge itself takes effect in the frame just starting.
        push(4, 0, 4'b1110, 7'b1000000, 1'b1);
        push(4, 1, 4'b1101, 7'h7F, 1'b1);
        push(4, 2, 4'b1011, 7'h7F, 1'b1);
        push(4, 3, 4'b0111, 7'h7F, 1'b1);
        load_at(64, 16'h0000, 4'h0, 4'h0, 4'h0, 1'b1);

        // Blink digit 0: phase flips every 2 frames from reset (dark in frames 6,7).
        push_plain(5, 16'h1234, 1'b0);
        push_plain(6, 16'h1234, 1'b1);
        push_plain(7, 16'h1234, 1'b1);
        push_plain(8, 16'h1234, 1'b0);
        push_plain(9, 16'h1234, 1'b0);
        load_at(70, 16'h1234, 4'h0, 4'h0, 4'b0001, 1'b0);

        push(10, 0, 4'b1110, 7'b0000000, 1'b1);
        push(10, 1, 4'b1101, 7'b1111000, 1'b1);
        push(10, 2, 4'b1011, 7'b0000010, 1'b0);
        push(10, 3, 4'b1111, 7'h7F, 1'b1);
        load_at(147, 16'h5678, 4'b0100, 4'b1000, 4'h0, 1'b0);

        // LZB digit keeps its decimal point.
        push(11, 0, 4'b1110, 7'b0010010, 1'b1);
        push(11, 1, 4'b1101, 7'h7F, 1'b1);
        push(11, 2, 4'b1011, 7'h7F, 1'b1);
        push(11, 3, 4'b0111, 7'h7F, 1'b0);
        load_at(165, 16'h0005, 4'b1000, 4'h0, 4'h0, 1'b1);

        // A blanked nonzero digit still stops leading-zero blanking below it.
        push(12, 0, 4'b1110, 7'b1000000, 1'b1);
        push(12, 1, 4'b1101, 7'b1000000, 1'b1);
        push(12, 2, 4'b1111, 7'h7F, 1'b1);
        push(12, 3, 4'b0111, 7'h7F, 1'b1);
        load_at(185, 16'h0300, 4'h0, 4'b0100, 4'h0, 1'b1);

        while (cyc != 16 * 13 + 2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("tick_seen", seen_tick, 1'b1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/seg_display_scanner.md
Name: seg_display_scanner

Overview:
Parametrised multiplexed seven-segment display driver for the board display path; successor to the fixed 4-digit display controller.
- Scans NUM_DIGITS common-anode digits from packed hex nibbles.
- Adds per-digit decimal point, forced blank, blink, optional leading-zero blanking and tear-free frame-synchronous update.
- Sits between processor/datapath status logic and the an/seg/dp board pins; runs on the fast board clock.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8).
REFRESH_DIV, 100000, clk cycles each digit stays lit (>= 2).
BLINK_FRAMES, 64, full scan frames per blink half-period (>= 1).

Ports:
clk  in  1  board clock, single clock domain
reset  in  1  asynchronous, active-high; clears all state
digits_in  in  4*NUM_DIGITS  hex nibbles; digit i at [4i+3:4i]; digit 0 rightmost
dp_in  in  NUM_DIGITS  1 = light decimal point of digit i
blank_in  in  NUM_DIGITS  1 = digit i fully dark (anode off)
blink_in  in  NUM_DIGITS  1 = digit i blinks
lz_blank_en  in  1  enable leading-zero blanking
load  in  1  capture all *_in vectors and lz_blank_en (level-sampled each cycle)
an  out  NUM_DIGITS  anode enables, active-low, one-hot-low
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low
frame_tick  out  1  one-cycle pulse at frame start (scan index wraps to 0)

Behaviour:
- Reset (async, immediate): an all 1, seg 7'h7F, dp 1, frame_tick 0; slot counter, scan index, blink counter, blink_phase, pending all 0; staging and display registers 0.
- Slot counter runs 0..REFRESH_DIV-1. At terminal count the scan index increments, wrapping NUM_DIGITS-1 -> 0; this wrap is the frame boundary.
- frame_tick is registered: high for exactly the cycle the index becomes 0.
- an, seg and dp are registered. They reflect the new index one cycle after the index changes and are never two-hot.
- Load:
  - load=1 writes inputs into staging registers and sets pending.
  - At a frame boundary with pending=1, staging copies to display registers and pending clears.
  - load coinciding with a boundary: current inputs go straight to the display registers and pending clears.
  - Repeated loads within a frame: the last one wins.
- Digit render priority, for the digit at the current index:
  1. blank_in, or (blink_in and blink_phase=1): an bit 1, seg 7F, dp 1.
  2. LZB: lz_blank_en=1, value 0, all higher-index values 0, index != 0. Result: anode low, seg 7F, dp per dp_in.
  3. Otherwise: anode low, seg = hex decode, dp = ~dp_in bit.
- LZB evaluates digit values only; blank_in does not affect it.
- Blink counter counts frame boundaries 0..BLINK_FRAMES-1. At wrap, blink_phase toggles. Blink is global in phase across all digits.
- Hex decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Display registers are only ever updated at frame boundaries, so a frame never mixes old and new data.
- Reset asserted mid-frame: outputs dark in the same cycle. After release, scanning restarts at index 0 with display data 0. The first frame_tick comes after one full frame.

Decomposition:
- Package seg_pkg holds:
  - the 16-entry HEX_TO_SEG constant table
  - SEG_BLANK = 7'h7F
  - the digit-attribute struct type {value[3:0], dp, blank, blink}
- One sub-module, seg_hex_decoder: combinational nibble -> 7-bit active-low pattern, using seg_pkg.
- The scanner instantiates one seg_hex_decoder on the muxed current digit.

Test Plan:
All tests use NUM_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2.
1. Reset pulse mid-scan -> same cycle an=1111, seg=7F, dp=1, frame_tick=0. After release, the first frame_tick arrives 16 cycles later.
2. load one cycle with digits_in=16'h12AF, others 0 -> from next frame an sequences 1110/1101/1011/0111, each 4 cycles. seg = 0001110, 0001000, 0100100, 1111001 respectively.
3. Displaying 16'h12AF, load 16'h3333 in mid-frame -> remaining slots still show 12AF; all digits show 0110000 only after frame_tick.
4. lz_blank_en=1, digits 16'h0070 -> digits 3 and 2 have seg=7F with anode low; digit1=1111000; digit0=1000000. With 16'h0000 only digit0 shows 1000000.
5. blink_in=0001 -> digit0 anode stays high for 2 frames, then lit for 2 frames, alternating. Digits 1-3 unaffected.
6. dp_in=0100, blank_in=1000 -> dp=0 only during digit2 slot. an[3] never 0. dp=1 in all other slots.
